except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/except_ctrl_pkg.sv | 40 ++++
 rtl/outst_counter.sv | 36 +++
 rtl/except_ctrl.sv | 138 +++++++++++++
 tb/tb_except_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared types and constants for the exception/ERET sequencer.
// Build option: EXC_DRAIN_TIMEOUT_EN enables the drain watchdog in except_ctrl.
package except_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } exc_state_e;

    localparam logic [XLEN-1:0] EXC_INT   = 32'h0000_0001;
    localparam logic [XLEN-1:0] EXC_ADEL  = 32'h0000_0004;
    localparam logic [XLEN-1:0] EXC_ADES  = 32'h0000_0005;
    localparam logic [XLEN-1:0] EXC_SYS   = 32'h0000_0008;
    localparam logic [XLEN-1:0] EXC_BP    = 32'h0000_0009;
    localparam logic [XLEN-1:0] EXC_RI    = 32'h0000_000a;
    localparam logic [XLEN-1:0] EXC_OV    = 32'h0000_000c;
    localparam logic [XLEN-1:0] EXC_ERET  = 32'h0000_000e;
    localparam logic [XLEN-1:0] EXC_ENTRY = 32'hBFC0_0380;

    // Exception record captured when a request is accepted
    typedef struct packed {
        logic              is_eret;
        logic [CODE_W-1:0] code;
        logic [XLEN-1:0]   tgt;
        logic [XLEN-1:0]   epc;
        logic              bd;
        logic [XLEN-1:0]   badvaddr;
    } exc_rec_t;

    // EPC points at the branch when the faulting instruction sits in a delay slot
    function automatic logic [XLEN-1:0] epc_of(input logic [XLEN-1:0] pc, input logic ds);
        return ds ? (pc - XLEN'(4)) : pc;
    endfunction

endpackage

// File: rtl/outst_counter.sv
// Saturating count of data transactions accepted but not yet answered.
module outst_counter #(
    parameter int unsigned OUTST_W = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               inc,
    input  logic               dec,
    input  logic               clr,
    output logic [OUTST_W-1:0] cnt_next_c
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    logic [OUTST_W-1:0] cnt_q;

    always_comb begin
        cnt_next_c = cnt_q;
        if (clr) begin
            cnt_next_c = '0;
        end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_next_c = cnt_q + OUTST_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_next_c = cnt_q - OUTST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next_c;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception/ERET sequencer: drains outstanding data accesses, commits CP0, redirects PC.
// Build option: EXC_DRAIN_TIMEOUT_EN adds a drain watchdog (TIMEOUT_CYC) and sticky timeout_err.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter int unsigned OUTST_W     = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        is_except,
    input  logic [31:0] except_type,
    input  logic [31:0] except_pc,
    input  logic [31:0] pc_m,
    input  logic        in_delayslot_m,
    input  logic [31:0] bad_addr_m,
    input  logic        data_req,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        mem_req_block,
    output logic        stall_all,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        cp0_except_we,
    output logic        cp0_eret,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    exc_state_e         state_q, state_d;
    exc_rec_t           rec_q, rec_d;
    logic [OUTST_W-1:0] cnt_next_c;
    logic               cnt_clr;

    outst_counter #(.OUTST_W(OUTST_W)) u_outst (
        .clk        (clk),
        .resetn     (resetn),
        .inc        (data_req & data_addr_ok),
        .dec        (data_data_ok),
        .clr        (cnt_clr),
        .cnt_next_c (cnt_next_c)
    );

`ifdef EXC_DRAIN_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            drain_to_c;

    // Watchdog counts consecutive DRAIN cycles; expiry empties the counter to force COMMIT
    assign drain_to_c = (state_q == ST_DRAIN) && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign cnt_clr    = drain_to_c;
    assign wd_d       = ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) ? (wd_q + WD_W'(1)) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            timeout_err <= timeout_err | drain_to_c;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^32'(TIMEOUT_CYC);
    assign cnt_clr     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next state and record capture
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        case (state_q)
            ST_IDLE: begin
                if (is_except) begin
                    rec_d.is_eret  = (except_type == EXC_ERET);
                    rec_d.code     = except_type[CODE_W-1:0];
                    rec_d.tgt      = except_pc;
                    rec_d.epc      = epc_of(pc_m, in_delayslot_m);
                    rec_d.bd       = in_delayslot_m;
                    rec_d.badvaddr = bad_addr_m;
                    state_d        = (cnt_next_c == '0) ? ST_COMMIT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_next_c == '0) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            rec_q          <= '0;
            busy           <= 1'b0;
            stall_all      <= 1'b0;
            flush_all      <= 1'b0;
            cp0_except_we  <= 1'b0;
            cp0_eret       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mem_req_block  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rec_q          <= rec_d;
            busy           <= (state_d != ST_IDLE);
            stall_all      <= (state_d == ST_DRAIN);
            flush_all      <= (state_d == ST_COMMIT) || (state_d == ST_REDIRECT);
            cp0_except_we  <= (state_d == ST_COMMIT) && !rec_d.is_eret;
            cp0_eret       <= (state_d == ST_COMMIT) && rec_d.is_eret;
            redirect_valid <= (state_d == ST_REDIRECT);
            redirect_pc    <= (state_d == ST_REDIRECT) ? rec_d.tgt : '0;
            mem_req_block  <= (state_d != ST_IDLE) || (cnt_next_c == CNT_MAX);
        end
    end

    assign cp0_exccode  = rec_q.code;
    assign cp0_epc      = rec_q.epc;
    assign cp0_bd       = rec_q.bd;
    assign cp0_badvaddr = rec_q.badvaddr;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed scoreboard bench for except_ctrl (OUTST_W=2, TIMEOUT_CYC=8).
module tb_except_ctrl;
    import except_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        is_except = 1'b0;
    logic [31:0] except_type = '0;
    logic [31:0] except_pc = '0;
    logic [31:0] pc_m = '0;
    logic        in_delayslot_m = 1'b0;
    logic [31:0] bad_addr_m = '0;
    logic        data_req = 1'b0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic        mem_req_block, stall_all, flush_all, redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_except_we, cp0_eret;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc;
    logic        cp0_bd;
    logic [31:0] cp0_badvaddr;
    logic        busy, timeout_err;

    except_ctrl #(.OUTST_W(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .resetn(resetn), .is_except(is_except), .except_type(except_type),
        .except_pc(except_pc), .pc_m(pc_m), .in_delayslot_m(in_delayslot_m),
        .bad_addr_m(bad_addr_m), .data_req(data_req), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .mem_req_block(mem_req_block), .stall_all(stall_all),
        .flush_all(flush_all), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cp0_except_we(cp0_except_we), .cp0_eret(cp0_eret), .cp0_exccode(cp0_exccode),
        .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] bad;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        is_except    = 1'b0;
        data_req     = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // Drive an exception request for the current cycle and record what CP0 should see
    task automatic send_exc(input logic [31:0] t, input logic [31:0] tgt, input logic [31:0] pc,
                            input logic ds, input logic [31:0] bad);
        exp_t e;
        logic [31:0] tv;
        tv = t;
        is_except      = 1'b1;
        except_type    = t;
        except_pc      = tgt;
        pc_m           = pc;
        in_delayslot_m = ds;
        bad_addr_m     = bad;
        e.is_eret = (tv == 32'h0000_000e);
        e.code    = tv[4:0];
        e.epc     = ds ? (pc - 32'd4) : pc;
        e.bd      = ds;
        e.bad     = bad;
        e.tgt     = tgt;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the COMMIT strobe, then check COMMIT, REDIRECT and return to IDLE
    task automatic wait_commit(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            idle_inputs();
            n++;
        end while (!(cp0_except_we || cp0_eret) && n < 40);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " we"},       32'(cp0_except_we), 32'(!e.is_eret));
            chk({tag, " eret"},     32'(cp0_eret),      32'(e.is_eret));
            chk({tag, " exccode"},  32'(cp0_exccode),   32'(e.code));
            chk({tag, " epc"},      cp0_epc,            e.epc);
            chk({tag, " bd"},       32'(cp0_bd),        32'(e.bd));
            chk({tag, " badvaddr"}, cp0_badvaddr,       e.bad);
            chk({tag, " c.flush"},  32'(flush_all),     32'd1);
            chk({tag, " c.stall"},  32'(stall_all),     32'd0);
            tick();
            chk({tag, " rd.valid"}, 32'(redirect_valid), 32'd1);
            chk({tag, " rd.pc"},    redirect_pc,         e.tgt);
            chk({tag, " rd.flush"}, 32'(flush_all),      32'd1);
            chk({tag, " rd.strb"},  32'({cp0_except_we, cp0_eret}), 32'd0);
            tick();
            chk({tag, " idle.busy"},  32'(busy),  32'd0);
            chk({tag, " idle.strb"},  32'({redirect_valid, flush_all, stall_all}), 32'd0);
            chk({tag, " idle.rdpc"},  redirect_pc, 32'd0);
            chk({tag, " idle.epc"},   cp0_epc,     e.epc);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst block",  32'(mem_req_block), 32'd0);
        chk("rst strobes", 32'({stall_all, flush_all, redirect_valid, cp0_except_we, cp0_eret, busy}), 32'd0);
        chk("rst rdpc",   redirect_pc,  32'd0);
        chk("rst code",   32'(cp0_exccode), 32'd0);
        chk("rst epc",    cp0_epc,      32'd0);
        chk("rst bd",     32'(cp0_bd),  32'd0);
        chk("rst bad",    cp0_badvaddr, 32'd0);
        chk("rst tmo",    32'(timeout_err), 32'd0);
        resetn = 1'b1;
        tick();

        // Plain exception, empty counter, then back-to-back ERET and delay-slot fault
        send_exc(EXC_SYS, EXC_ENTRY, 32'h8000_1000, 1'b0, 32'h0);
        wait_commit("sys", 1);
        send_exc(EXC_ERET, 32'h8000_2000, 32'h8000_1500, 1'b0, 32'h0);
        wait_commit("eret", 1);
        send_exc(EXC_RI, EXC_ENTRY, 32'h8000_0104, 1'b1, 32'h0);
        wait_commit("dslot", 1);

        // Two loads outstanding, then an address error drains before commit
        data_req = 1'b1; data_addr_ok = 1'b1;
        tick(); tick();
        idle_inputs();
        chk("two_out block", 32'(mem_req_block), 32'd0);
        send_exc(EXC_ADEL, EXC_ENTRY, 32'h8000_0200, 1'b0, 32'h1234_5679);
        tick();
        is_except = 1'b0;
        chk("drain stall", 32'(stall_all), 32'd1);
        chk("drain block", 32'(mem_req_block), 32'd1);
        chk("drain strb",  32'({flush_all, cp0_except_we, redirect_valid}), 32'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("drain1 stall", 32'(stall_all), 32'd1);
        tick();
        chk("drain2 stall", 32'(stall_all), 32'd1);
        data_data_ok = 1'b1;
        wait_commit("adel", 1);

        // Counter saturation, simultaneous inc/dec, decrement at zero
        data_req = 1'b1; data_addr_ok = 1'b1;
        repeat (3) tick();
        chk("sat3 block", 32'(mem_req_block), 32'd1);
        tick();
        chk("sat4 block", 32'(mem_req_block), 32'd1);
        data_req = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        chk("dec2 block", 32'(mem_req_block), 32'd0);
        data_req = 1'b1; data_addr_ok = 1'b1;
        tick(); tick();
        data_data_ok = 1'b0;
        chk("both block", 32'(mem_req_block), 32'd0);
        tick();
        idle_inputs();
        chk("inc3 block", 32'(mem_req_block), 32'd1);
        data_data_ok = 1'b1;
        repeat (4) tick();
        data_data_ok = 1'b0;
        chk("under block", 32'(mem_req_block), 32'd0);

        // A new request held through COMMIT and REDIRECT is ignored
        is_except = 1'b1; except_type = EXC_OV; except_pc = EXC_ENTRY;
        pc_m = 32'h8000_0300; in_delayslot_m = 1'b0; bad_addr_m = 32'h0;
        tick();
        chk("ov we",   32'(cp0_except_we), 32'd1);
        chk("ov code", 32'(cp0_exccode),   32'h0c);
        except_type = EXC_BP; pc_m = 32'h8000_0400;
        tick();
        chk("ov rd",      32'(redirect_valid), 32'd1);
        chk("ov rd code", 32'(cp0_exccode),    32'h0c);
        tick();
        idle_inputs();
        chk("ov idle busy", 32'(busy), 32'd0);
        tick();
        chk("ign busy", 32'(busy), 32'd0);
        chk("ign code", 32'(cp0_exccode), 32'h0c);
        chk("ign epc",  cp0_epc, 32'h8000_0300);

        // Reset in DRAIN abandons the sequence
        data_req = 1'b1; data_addr_ok = 1'b1;
        tick();
        idle_inputs();
        is_except = 1'b1; except_type = EXC_SYS; pc_m = 32'h8000_0500;
        tick();
        is_except = 1'b0;
        chk("rd drain stall", 32'(stall_all), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rd async", 32'({stall_all, busy, mem_req_block, flush_all}), 32'd0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd quiet", 32'({cp0_except_we, cp0_eret, redirect_valid, flush_all, busy}), 32'd0);
        end

`ifdef EXC_DRAIN_TIMEOUT_EN
        // Response never arrives: watchdog forces COMMIT after 8 DRAIN cycles
        data_req = 1'b1; data_addr_ok = 1'b1;
        tick();
        idle_inputs();
        send_exc(EXC_ADES, EXC_ENTRY, 32'h8000_0600, 1'b0, 32'h0000_0ff1);
        wait_commit("tmo", 9);
        chk("tmo err", 32'(timeout_err), 32'd1);
        chk("tmo block", 32'(mem_req_block), 32'd0);
        repeat (5) tick();
        chk("tmo sticky", 32'(timeout_err), 32'd1);
        resetn = 1'b0;
        #1;
        chk("tmo rst", 32'(timeout_err), 32'd0);
        tick();
        resetn = 1'b1;
`else
        chk("tmo tied", 32'(timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
